// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================
// Module : aes_ctrl_pkg - register map, FSM states, status bits
// Rev    : 1.0  initial release
// ============================================================
package aes_ctrl_pkg;

  localparam int WORDS  = 8;
  localparam int LAT_W  = 16;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int BLK_W  = WORDS * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_DIN    = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_DOUT   = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'h10;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h11;
  localparam logic [ADDR_W-1:0] ADDR_LAT    = 5'h12;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  // DIN occupies 0x00-0x07 and DOUT 0x08-0x0F, so bits [4:3] select the bank
  function automatic logic is_din(input logic [ADDR_W-1:0] a);
    return a[4:3] == 2'b00;
  endfunction

  function automatic logic is_dout(input logic [ADDR_W-1:0] a);
    return a[4:3] == 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_ctrl_if.sv
`default_nettype none
// ============================================================
// Module : aes_ctrl_if - CPU bus and encryptor handshake bundle
// Rev    : 1.0  initial release
// ============================================================
interface aes_ctrl_if;
  import aes_ctrl_pkg::*;

  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              we_i;
  logic              re_i;
  logic [DATA_W-1:0] rdata_o;
  logic              irq_o;
  logic [BLK_W-1:0]  enc_data_o;
  logic              enc_v_o;
  logic              enc_ready_i;
  logic [BLK_W-1:0]  enc_data_i;
  logic              enc_v_i;
  logic              enc_yumi_o;

  modport master (
    output addr_i, wdata_i, we_i, re_i, enc_ready_i, enc_data_i, enc_v_i,
    input  rdata_o, irq_o, enc_data_o, enc_v_o, enc_yumi_o
  );

  modport slave (
    input  addr_i, wdata_i, we_i, re_i, enc_ready_i, enc_data_i, enc_v_i,
    output rdata_o, irq_o, enc_data_o, enc_v_o, enc_yumi_o
  );

endinterface
`default_nettype wire

// File: rtl/aes_ctrl_regs.sv
`default_nettype none
// ============================================================
// Module : aes_ctrl_regs - DIN/DOUT word banks and readback mux
// Rev    : 1.0  initial release
// ============================================================
module aes_ctrl_regs
  import aes_ctrl_pkg::*;
(
  input  wire logic              clk_i,
  input  wire logic              reset_n_i,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_we,
  input  wire logic              i_re,
  input  wire logic              i_din_lock,
  input  wire logic              i_dout_cap,
  input  wire logic [BLK_W-1:0]  i_dout_data,
  input  wire logic              i_irq_en,
  input  wire logic [2:0]        i_status,
  input  wire logic [LAT_W-1:0]  i_lat,
  output logic      [BLK_W-1:0]  o_din,
  output logic      [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_din  [WORDS];
  logic [DATA_W-1:0] r_dout [WORDS];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rd_mux;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < WORDS; k++) begin
        r_din[k]  <= '0;
        r_dout[k] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we && is_din(i_addr) && !i_din_lock)
        r_din[i_addr[2:0]] <= i_wdata;
      if (i_dout_cap)
        for (int k = 0; k < WORDS; k++)
          r_dout[k] <= i_dout_data[k*DATA_W +: DATA_W];
      // Mux sees pre-edge state, so a same-cycle write is not reflected
      if (i_re)
        r_rdata <= w_rd_mux;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (is_din(i_addr)) begin
      w_rd_mux = r_din[i_addr[2:0]];
    end else if (is_dout(i_addr)) begin
      w_rd_mux = r_dout[i_addr[2:0]];
    end else begin
      case (i_addr)
        ADDR_CTRL:   w_rd_mux[CTRL_IRQ_EN] = i_irq_en;
        ADDR_STATUS: w_rd_mux[2:0]         = i_status;
        ADDR_LAT:    w_rd_mux              = i_lat;
        default:     w_rd_mux              = '0;
      endcase
    end
  end

  for (genvar k = 0; k < WORDS; k++) begin : g_din_pack
    assign o_din[k*DATA_W +: DATA_W] = r_din[k];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/aes_ctrl.sv
`default_nettype none
// ============================================================
// Module : aes_ctrl - CPU register front-end for the AES encryptor
// Rev    : 1.0  initial release
// ============================================================
module aes_ctrl
  import aes_ctrl_pkg::*;
(
  input wire logic   clk_i,
  input wire logic   reset_n_i,
  aes_ctrl_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_done;
  logic              r_err;
  logic              r_irq_en;
  logic [LAT_W-1:0]  r_lat;

  logic              w_busy;
  logic              w_ctrl_wr;
  logic              w_start_wr;
  logic              w_start_ok;
  logic              w_din_wr;
  logic              w_status_rd;
  logic              w_capture;
  logic              w_proto_err;
  logic              w_set_err;
  logic              w_enc_v;
  logic              w_enc_yumi;
  logic [2:0]        w_status;
  logic [BLK_W-1:0]  w_din;

  assign w_busy      = (r_state != IDLE);
  assign w_ctrl_wr   = bus.we_i && (bus.addr_i == ADDR_CTRL);
  assign w_start_wr  = w_ctrl_wr && bus.wdata_i[CTRL_START];
  assign w_start_ok  = w_start_wr && !w_busy;
  assign w_din_wr    = bus.we_i && is_din(bus.addr_i);
  assign w_status_rd = bus.re_i && (bus.addr_i == ADDR_STATUS);
  assign w_set_err   = w_proto_err || (w_busy && (w_din_wr || w_start_wr));

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_proto_err = 1'b0;
    w_enc_v     = 1'b0;
    w_enc_yumi  = 1'b0;
    case (r_state)
      IDLE: begin
        w_proto_err = bus.enc_v_i;
        if (w_start_wr)
          w_state_nxt = SEND;
      end
      SEND: begin
        w_enc_v     = 1'b1;
        w_proto_err = bus.enc_v_i;
        if (bus.enc_ready_i)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        w_enc_yumi = bus.enc_v_i;
        w_capture  = bus.enc_v_i;
        if (bus.enc_v_i)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
      r_lat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ctrl_wr)
        r_irq_en <= bus.wdata_i[CTRL_IRQ_EN];
      // A set in the same cycle as a STATUS read wins over the read-clear
      if (w_capture)
        r_done <= 1'b1;
      else if (w_status_rd || w_start_ok)
        r_done <= 1'b0;
      if (w_set_err)
        r_err <= 1'b1;
      else if (w_status_rd)
        r_err <= 1'b0;
      if (w_start_ok)
        r_lat <= '0;
      else if (w_busy && (r_lat != '1))
        r_lat <= r_lat + 1'b1;
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[STAT_BUSY] = w_busy;
    w_status[STAT_DONE] = r_done;
    w_status[STAT_ERR]  = r_err;
  end

  aes_ctrl_regs u_regs (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .i_addr      (bus.addr_i),
    .i_wdata     (bus.wdata_i),
    .i_we        (bus.we_i),
    .i_re        (bus.re_i),
    .i_din_lock  (w_busy),
    .i_dout_cap  (w_capture),
    .i_dout_data (bus.enc_data_i),
    .i_irq_en    (r_irq_en),
    .i_status    (w_status),
    .i_lat       (r_lat),
    .o_din       (w_din),
    .o_rdata     (bus.rdata_o)
  );

  assign bus.enc_data_o = w_din;
  assign bus.enc_v_o    = w_enc_v;
  assign bus.enc_yumi_o = w_enc_yumi;
  assign bus.irq_o      = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_aes_ctrl.sv
`default_nettype none
// ============================================================
// Module : tb_aes_ctrl - scoreboard bench with stub encryptor
// Rev    : 1.0  initial release
// ============================================================
module tb_aes_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] FIPS_PT = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] FIPS_CT = 128'h3925841D02DC09FBDC118597196A0B32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_ctrl_if bus();

  aes_ctrl dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {127'd0, act}, {127'd0, exp});
  endtask

  // Stand-in cipher: the FIPS-197 vector maps to its published ciphertext
  function automatic logic [127:0] enc_fn(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return {pt[63:0], pt[127:64]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  // Stub encryptor: ready after stall_cfg valid cycles, result in the lat_cfg-th wait cycle
  int           stall_cfg = 0;
  int           lat_cfg   = 1;
  bit           spurious  = 1'b0;
  int           stall_ctr = 0;
  int           wait_ctr  = 0;
  bit           pend      = 1'b0;
  logic [127:0] ct        = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      stall_ctr <= 0;
      wait_ctr  <= 0;
      pend      <= 1'b0;
    end else begin
      if (bus.enc_v_o && bus.enc_ready_i) begin
        stall_ctr <= 0;
        pend      <= 1'b1;
        wait_ctr  <= lat_cfg - 1;
        ct        <= enc_fn(bus.enc_data_o);
      end else if (bus.enc_v_o) begin
        stall_ctr <= stall_ctr + 1;
      end
      if (pend) begin
        if (wait_ctr == 0) begin
          if (bus.enc_yumi_o) pend <= 1'b0;
        end else begin
          wait_ctr <= wait_ctr - 1;
        end
      end
    end
  end

  assign bus.enc_ready_i = (stall_ctr >= stall_cfg);
  assign bus.enc_v_i     = (pend && wait_ctr == 0) || spurious;
  assign bus.enc_data_i  = ct;

  // Reference model of the programmer-visible state
  logic [127:0] m_din, m_dout;
  logic         m_irq_en, m_done, m_err, m_busy;
  logic [15:0]  m_lat;

  logic [15:0]  rd_exp_q  [$];
  string        rd_name_q [$];
  logic [127:0] pt_q      [$];

  task automatic model_reset();
    m_din = '0; m_dout = '0; m_irq_en = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_lat = '0;
  endtask

  task automatic model_complete();
    m_busy = 1'b0;
    m_done = 1'b1;
    m_dout = enc_fn(m_din);
  endtask

  function automatic logic [15:0] exp_read(input logic [4:0] a);
    if (a < 5'h08) return m_din[a[2:0]*16 +: 16];
    if (a < 5'h10) return m_dout[a[2:0]*16 +: 16];
    case (a)
      5'h10:   return {14'd0, m_irq_en, 1'b0};
      5'h11:   return {13'd0, m_err, m_done, m_busy};
      5'h12:   return m_lat;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a < 5'h08) begin
      if (m_busy) m_err = 1'b1;
      else        m_din[a[2:0]*16 +: 16] = d;
    end else if (a == 5'h10) begin
      m_irq_en = d[1];
      if (d[0]) begin
        if (m_busy) begin
          m_err = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_done = 1'b0;
          m_lat  = 16'(stall_cfg + 1 + lat_cfg);
          pt_q.push_back(m_din);
        end
      end
    end
  endtask

  // Bus tasks are entered and left on a falling edge
  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    model_write(a, d);
    bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
    @(negedge clk);
    bus.we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, input string name);
    rd_exp_q.push_back(exp_read(a));
    rd_name_q.push_back(name);
    if (a == 5'h11) begin m_done = 1'b0; m_err = 1'b0; end
    bus.re_i = 1'b1; bus.addr_i = a;
    @(negedge clk);
    bus.re_i = 1'b0;
  endtask

  task automatic bus_rw(input logic [4:0] a, input logic [15:0] d, input string name);
    rd_exp_q.push_back(exp_read(a));
    rd_name_q.push_back(name);
    model_write(a, d);
    bus.we_i = 1'b1; bus.re_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
    @(negedge clk);
    bus.we_i = 1'b0; bus.re_i = 1'b0;
  endtask

  task automatic load_din(input logic [127:0] v);
    for (int k = 0; k < 8; k++) bus_write(5'(k), v[k*16 +: 16]);
  endtask

  task automatic start_block(input int s, input int l, input logic irq);
    stall_cfg = s;
    lat_cfg   = l;
    bus_write(5'h10, {14'd0, irq, 1'b1});
  endtask

  task automatic wait_capture();
    for (int i = 0; i < 200 && !bus.enc_yumi_o; i++) @(negedge clk);
    chk1("capture_seen", bus.enc_yumi_o, 1'b1);
  endtask

  task automatic read_results(input string tag);
    bus_read(5'h11, {tag, "_status"});
    bus_read(5'h12, {tag, "_lat"});
    for (int k = 0; k < 8; k++) bus_read(5'(8 + k), $sformatf("%s_dout%0d", tag, k));
  endtask

  // Monitor: read responses and issued blocks are checked against the queues
  logic rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= bus.re_i;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected: got %h expected no read", bus.rdata_o);
      end else begin
        check(rd_name_q.pop_front(), {112'd0, bus.rdata_o}, {112'd0, rd_exp_q.pop_front()});
      end
    end
    if (reset_n && bus.enc_v_o && bus.enc_ready_i) begin
      if (pt_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_block: got block %h expected none", bus.enc_data_o);
      end else begin
        check("block_pt", bus.enc_data_o, pt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v;
    logic [15:0]  w;
    bus.addr_i = '0; bus.wdata_i = '0; bus.we_i = 1'b0; bus.re_i = 1'b0;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    chk1("rst_enc_v", bus.enc_v_o, 1'b0);
    chk1("rst_yumi", bus.enc_yumi_o, 1'b0);
    chk1("rst_irq", bus.irq_o, 1'b0);
    check("rst_rdata", {112'd0, bus.rdata_o}, 128'd0);
    for (int a = 0; a <= 5'h13; a++) bus_read(5'(a), $sformatf("rst_reg_%0h", a));
    bus_read(5'h1F, "rst_reg_1f");

    // FIPS-197 block, minimum latency
    load_din(FIPS_PT);
    bus_read(5'h07, "fips_din7");
    start_block(0, 1, 1'b0);
    wait_capture(); @(negedge clk); model_complete();
    read_results("fips");
    bus_read(5'h11, "fips_status2");

    // Backpressure: ready low 5 cycles, result latency 3
    v = {$urandom, $urandom, $urandom, $urandom};
    load_din(v);
    start_block(5, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", bus.enc_v_o, 1'b1);
      check("bp_data", bus.enc_data_o, m_din);
      @(negedge clk);
    end
    wait_capture(); @(negedge clk); model_complete();
    read_results("bp");

    // Busy misuse during WAIT
    v = {$urandom, $urandom, $urandom, $urandom};
    load_din(v);
    start_block(0, 12, 1'b0);
    @(negedge clk);
    bus_write(5'h00, 16'hFFFF);
    bus_write(5'h10, 16'h0001);
    bus_read(5'h11, "misuse_status_err");
    wait_capture(); @(negedge clk); model_complete();
    bus_read(5'h11, "misuse_status_clr");
    bus_read(5'h00, "misuse_din0");
    read_results("misuse");

    // STATUS read in the capture cycle, with interrupt enabled
    v = {$urandom, $urandom, $urandom, $urandom};
    load_din(v);
    start_block(0, 3, 1'b1);
    wait_capture();
    chk1("irq_pre", bus.irq_o, 1'b0);
    bus_read(5'h11, "collide_status");
    model_complete();
    chk1("irq_rise", bus.irq_o, 1'b1);
    bus_read(5'h11, "collide_status_next");
    chk1("irq_fall", bus.irq_o, 1'b0);

    // Spurious result while idle
    spurious = 1'b1;
    #2;
    chk1("proto_yumi", bus.enc_yumi_o, 1'b0);
    @(negedge clk);
    spurious = 1'b0;
    m_err = 1'b1;
    bus_read(5'h11, "proto_status");

    // Same-cycle write and read returns the old value
    w = 16'($urandom);
    bus_rw(5'h03, w, "rw_old");
    bus_read(5'h03, "rw_new");

    // Reset while waiting for the result
    v = {$urandom, $urandom, $urandom, $urandom};
    load_din(v);
    start_block(0, 10, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    chk1("mid_rst_yumi", bus.enc_yumi_o, 1'b0);
    chk1("mid_rst_enc_v", bus.enc_v_o, 1'b0);
    chk1("mid_rst_irq", bus.irq_o, 1'b0);
    for (int a = 0; a <= 5'h12; a++) bus_read(5'(a), $sformatf("mid_rst_reg_%0h", a));
    load_din(FIPS_PT);
    start_block(0, 1, 1'b0);
    wait_capture(); @(negedge clk); model_complete();
    read_results("fips2");

    // Randomised blocks
    for (int it = 0; it < 12; it++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      load_din(v);
      start_block(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      wait_capture(); @(negedge clk); model_complete();
      chk1("rnd_irq", bus.irq_o, m_irq_en);
      bus_read(5'($urandom_range(0, 7)), "rnd_din");
      read_results("rnd");
    end

    repeat (3) @(negedge clk);
    check("blocks_drained", 128'(pt_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
